// File: rtl/store_data_issue_queue.sv
// store_data_issue_queue
//   Holds store-data register lookups until the data tag is ready, then hands
//   the one with the oldest storeSqN to the store-data load stage through a
//   registered output slot.
//
//   Ports
//     clk, rst       clock; synchronous active-high reset
//     IN_branch      branch broadcast: taken, flush, storeSqN
//     IN_uop         enqueue candidate (valid, tag, storeSqN, offs)
//     IN_uopAvail    IN_uop.tag is already in the register file
//     OUT_full       registered; queue accepts nothing this cycle
//     IN_wakeValid   per-port result-bus valid
//     IN_wakeTag     per-port result-bus tag
//     IN_issueReady  downstream accepts OUT_uop
//     OUT_uop        issued lookup (registered)
//
//   Build option
//     STDIQ_BYPASS_EN  a ready IN_uop goes straight to OUT_uop when no queued
//                      entry is ready and the output slot is free.
//
//   Tags with the MSB set are immediates: always ready, never woken.

package store_data_issue_queue_pkg;
  localparam int TAG_W  = 7;
  localparam int SQN_W  = 8;
  localparam int OFFS_W = 4;

  typedef logic [TAG_W-1:0] Tag;
  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic taken;
    logic flush;
    SqN   storeSqN;
  } BranchProv;

  typedef struct packed {
    logic              valid;
    Tag                tag;
    SqN                storeSqN;
    logic [OFFS_W-1:0] offs;
  } StDataLookupUOp;

  // Younger than the branch (wrapping difference > 0), or a full flush.
  function automatic logic br_kill(input BranchProv br, input SqN sqn);
    SqN d;
    d = sqn - br.storeSqN;
    return br.taken && (br.flush || (!d[SQN_W-1] && (d != '0)));
  endfunction

  // a is older than b under wrapping sequence numbers.
  function automatic logic sqn_older(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction
endpackage

// One queue slot: occupancy, readiness and the held lookup.
module store_data_issue_queue_entry
  import store_data_issue_queue_pkg::*;
#(
  parameter int NUM_WAKE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  BranchProv           branch,
  input  logic [NUM_WAKE-1:0] wake_valid,
  input  Tag   [NUM_WAKE-1:0] wake_tag,
  input  logic                enq,
  input  StDataLookupUOp      enq_uop,
  input  logic                enq_rdy,
  input  logic                issue,
  output logic                valid,
  output logic                rdy,
  output StDataLookupUOp      uop,
  output logic                kill
);
  logic wake;

  always_comb begin
    wake = 1'b0;
    for (int i = 0; i < NUM_WAKE; i++)
      if (wake_valid[i] && (wake_tag[i] == uop.tag)) wake = 1'b1;
    if (uop.tag[TAG_W-1]) wake = 1'b0;
  end

  assign kill = valid && br_kill(branch, uop.storeSqN);

  // enq only targets a free slot, so it never collides with kill/issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdy   <= 1'b0;
    end else if (kill || issue) begin
      valid <= 1'b0;
      rdy   <= 1'b0;
    end else if (enq) begin
      valid <= 1'b1;
      rdy   <= enq_rdy;
    end else if (valid && wake) begin
      rdy   <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (enq) uop <= enq_uop;
endmodule

module store_data_issue_queue
  import store_data_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int NUM_WAKE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  BranchProv           IN_branch,
  input  StDataLookupUOp      IN_uop,
  input  logic                IN_uopAvail,
  output logic                OUT_full,
  input  logic [NUM_WAKE-1:0] IN_wakeValid,
  input  Tag   [NUM_WAKE-1:0] IN_wakeTag,
  input  logic                IN_issueReady,
  output StDataLookupUOp      OUT_uop
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]           ent_valid, ent_rdy, ent_kill, ent_enq, ent_issue;
  StDataLookupUOp [DEPTH-1:0] ent_uop;

  logic [CNT_W-1:0] occ, occ_nxt, kill_cnt;
  logic             in_kill, in_wake, in_rdy, out_free;
  logic             sel_found, free_found, issue_go, enq_go, byp;
  logic [IDX_W-1:0] sel_idx, free_idx;
  StDataLookupUOp   out_nxt;

  assign in_kill  = br_kill(IN_branch, IN_uop.storeSqN);
  assign out_free = !OUT_uop.valid || IN_issueReady;

  always_comb begin
    in_wake = 1'b0;
    for (int i = 0; i < NUM_WAKE; i++)
      if (IN_wakeValid[i] && (IN_wakeTag[i] == IN_uop.tag)) in_wake = 1'b1;
  end
  assign in_rdy = IN_uop.tag[TAG_W-1] || IN_uopAvail || in_wake;

  // Oldest ready entry; entries being killed this edge are not candidates.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent_rdy[i] && !ent_kill[i] &&
          (!sel_found || sqn_older(ent_uop[i].storeSqN, ent_uop[sel_idx].storeSqN))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
  end

`ifdef STDIQ_BYPASS_EN
  assign byp = IN_uop.valid && in_rdy && !in_kill && out_free && !sel_found;
`else
  assign byp = 1'b0;
`endif

  assign issue_go = out_free && sel_found;
  // OUT_full is last cycle's view: a same-cycle issue does not open a slot.
  assign enq_go   = IN_uop.valid && !OUT_full && !in_kill && !byp && free_found;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign ent_enq[g]   = enq_go   && (free_idx == IDX_W'(g));
      assign ent_issue[g] = issue_go && (sel_idx  == IDX_W'(g));
      store_data_issue_queue_entry #(.NUM_WAKE(NUM_WAKE)) u_ent (
        .clk        (clk),
        .rst        (rst),
        .branch     (IN_branch),
        .wake_valid (IN_wakeValid),
        .wake_tag   (IN_wakeTag),
        .enq        (ent_enq[g]),
        .enq_uop    (IN_uop),
        .enq_rdy    (in_rdy),
        .issue      (ent_issue[g]),
        .valid      (ent_valid[g]),
        .rdy        (ent_rdy[g]),
        .uop        (ent_uop[g]),
        .kill       (ent_kill[g])
      );
    end
  endgenerate

  // Issued entries are never in the kill set, so the terms are disjoint.
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) kill_cnt = kill_cnt + CNT_W'(ent_kill[i]);
  end
  assign occ_nxt = occ + CNT_W'(enq_go) - CNT_W'(issue_go) - kill_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      OUT_full <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      OUT_full <= (occ_nxt == CNT_W'(DEPTH));
    end
  end

  always_comb begin
    out_nxt = OUT_uop;
    if (out_free) begin
      out_nxt.valid = 1'b0;
      if (sel_found) begin
        out_nxt       = ent_uop[sel_idx];
        out_nxt.valid = 1'b1;
      end else if (byp) begin
        out_nxt       = IN_uop;
        out_nxt.valid = 1'b1;
      end
    end else if (br_kill(IN_branch, OUT_uop.storeSqN)) begin
      out_nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) OUT_uop.valid <= 1'b0;
    else     OUT_uop       <= out_nxt;
  end
endmodule

// File: tb/tb_store_data_issue_queue.sv
// Directed bench for store_data_issue_queue (DEPTH=8, NUM_WAKE=4).
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_store_data_issue_queue;
  import store_data_issue_queue_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  BranchProv      br;
  StDataLookupUOp uop_in, uop_out;
  logic           avail, full, issue_rdy;
  logic [3:0]     wake_v;
  Tag   [3:0]     wake_t;

  int n_chk  = 0;
  int n_fail = 0;

  store_data_issue_queue #(.DEPTH(8), .NUM_WAKE(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_branch     (br),
    .IN_uop        (uop_in),
    .IN_uopAvail   (avail),
    .OUT_full      (full),
    .IN_wakeValid  (wake_v),
    .IN_wakeTag    (wake_t),
    .IN_issueReady (issue_rdy),
    .OUT_uop       (uop_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    uop_in = '0;
    wake_v = '0;
    wake_t = '0;
    br     = '0;
    avail  = 1'b0;
  endtask

  task automatic put(input logic [6:0] tag, input logic [7:0] sqn);
    uop_in.valid    = 1'b1;
    uop_in.tag      = tag;
    uop_in.storeSqN = sqn;
    uop_in.offs     = sqn[3:0];
  endtask

  initial begin
    idle();
    issue_rdy = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_out_v", uop_out.valid, 0);
    chk("rst_full",  full,          0);
    chk("rst_occ",   dut.occ,       0);

    // immediate tag, sqN 5
    put(7'h45, 8'd5);
    step();
    idle();
`ifdef STDIQ_BYPASS_EN
    chk("imm_v",    uop_out.valid,    1);
    chk("imm_sqn",  uop_out.storeSqN, 5);
`else
    chk("imm_v1",   uop_out.valid,    0);
    chk("imm_occ1", dut.occ,          1);
    step();
    chk("imm_v",    uop_out.valid,    1);
    chk("imm_sqn",  uop_out.storeSqN, 5);
    chk("imm_offs", uop_out.offs,     5);
`endif
    step();
    chk("imm_drain", uop_out.valid, 0);

    // wake on successive cycles: wake order wins
    put(7'h12, 8'd3); step();
    put(7'h13, 8'd2); step();
    idle();
    wake_v[0] = 1'b1; wake_t[0] = 7'h12; step();
    chk("w_seq_none", uop_out.valid, 0);
    wake_t[0] = 7'h13; step();
    idle();
    chk("w_seq_1v",  uop_out.valid,    1);
    chk("w_seq_1",   uop_out.storeSqN, 3);
    step();
    chk("w_seq_2",   uop_out.storeSqN, 2);
    step();
    chk("w_seq_end", uop_out.valid,    0);

    // wake together: oldest storeSqN first
    put(7'h12, 8'd3); step();
    put(7'h13, 8'd2); step();
    idle();
    wake_v = 4'b0011; wake_t[0] = 7'h12; wake_t[1] = 7'h13; step();
    idle(); step();
    chk("w_same_1",   uop_out.storeSqN, 2);
    step();
    chk("w_same_2",   uop_out.storeSqN, 3);
    step();
    chk("w_same_end", uop_out.valid,    0);
    chk("w_same_occ", dut.occ,          0);

    // fill to full, 9th ignored, issue while full does not admit it
    for (int i = 0; i < 8; i++) begin
      put(7'h20 + 7'(i), 8'd10 + 8'(i));
      step();
    end
    idle();
    chk("full_set", full,    1);
    chk("full_occ", dut.occ, 8);
    put(7'h30, 8'd20); step();
    chk("full_9th_occ", dut.occ, 8);
    wake_v[0] = 1'b1; wake_t[0] = 7'h23; step();
    chk("full_wake_occ", dut.occ, 8);
    wake_v = '0; step();
    idle();
    chk("full_iss_v",   uop_out.valid,    1);
    chk("full_iss_sqn", uop_out.storeSqN, 13);
    chk("full_clr",     full,             0);
    chk("full_occ7",    dut.occ,          7);
    step();
    wake_v[0] = 1'b1; wake_t[0] = 7'h30; step();
    idle(); step();
    chk("full_9th_never", uop_out.valid, 0);
    chk("full_occ7b",     dut.occ,       7);
    br.taken = 1'b1; br.flush = 1'b1; step();
    idle();
    chk("full_flush_occ",  dut.occ, 0);
    chk("full_flush_full", full,    0);

    // partial kill with output held
    issue_rdy = 1'b0;
    put(7'h41, 8'd4); step();
    put(7'h42, 8'd6); step();
    put(7'h43, 8'd8); step();
    idle();
    chk("pk_hold4", uop_out.storeSqN, 4);
    chk("pk_occ2",  dut.occ,          2);
    br.taken = 1'b1; br.storeSqN = 8'd5; step();
    idle();
    chk("pk_out_v",   uop_out.valid,    1);
    chk("pk_out_sqn", uop_out.storeSqN, 4);
    chk("pk_occ0",    dut.occ,          0);
    issue_rdy = 1'b1; step();
    chk("pk_drain", uop_out.valid, 0);

    // wrapping sqN compare; equal sqN survives
    issue_rdy = 1'b0;
    put(7'h41, 8'hFD); step();
    put(7'h42, 8'hFE); step();
    put(7'h43, 8'h01); step();
    idle();
    br.taken = 1'b1; br.storeSqN = 8'hFE; step();
    idle();
    chk("wr_out_v",   uop_out.valid,    1);
    chk("wr_out_sqn", uop_out.storeSqN, 32'hFD);
    chk("wr_occ1",    dut.occ,          1);
    issue_rdy = 1'b1; step();
    chk("wr_next",    uop_out.storeSqN, 32'hFE);
    step();
    chk("wr_end_v",   uop_out.valid,    0);
    chk("wr_end_occ", dut.occ,          0);

    // flush with concurrent enqueue and held output
    issue_rdy = 1'b0;
    put(7'h44, 8'd30); step();
    put(7'h15, 8'd31); step();
    put(7'h46, 8'd40); br.taken = 1'b1; br.flush = 1'b1; step();
    idle();
    chk("fl_out_v", uop_out.valid, 0);
    chk("fl_full",  full,          0);
    chk("fl_occ",   dut.occ,       0);
    step();
    chk("fl_out_v2", uop_out.valid, 0);

    // reset over a busy queue and concurrent inputs
    for (int i = 0; i < 6; i++) begin
      put(7'h48 + 7'(i), 8'd50 + 8'(i));
      step();
    end
    idle();
    chk("rq_occ5", dut.occ,          5);
    chk("rq_out",  uop_out.storeSqN, 50);
    rst = 1'b1; issue_rdy = 1'b1;
    put(7'h40, 8'd60);
    wake_v[0] = 1'b1; wake_t[0] = 7'h12;
    br.taken = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("rq_out_v", uop_out.valid, 0);
    chk("rq_occ",   dut.occ,       0);
    chk("rq_full",  full,          0);
    step(); step();
    chk("rq_no_old", uop_out.valid, 0);
    chk("rq_occ_b",  dut.occ,       0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_data_issue_queue.md
STORE_DATA_ISSUE_QUEUE -- requirements
Module: store_data_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries (power of two, 2..32).
REQ-002 Parameter NUM_WAKE, default 4, number of result-bus wakeup ports.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 IN_branch  input  BranchProv  branch/flush broadcast (taken, flush, storeSqN).
REQ-006 IN_uop  input  StDataLookupUOp  enqueue candidate (valid, tag, storeSqN, offs).
REQ-007 IN_uopAvail  input  1  IN_uop.tag value is already present in the register file.
REQ-008 OUT_full  output  1  queue cannot accept IN_uop this cycle.
REQ-009 IN_wakeValid  input  NUM_WAKE  per-port result valid.
REQ-010 IN_wakeTag  input  NUM_WAKE x Tag  per-port produced tag.
REQ-011 IN_issueReady  input  1  downstream store-data load stage accepts OUT_uop.
REQ-012 OUT_uop  output  StDataLookupUOp  issued lookup, registered.

Function
REQ-013 Each entry SHALL hold valid, rdy, tag, storeSqN, offs.
REQ-014 Enqueue SHALL occur when IN_uop.valid && !OUT_full && IN_uop is not killed (REQ-021), into the lowest-index free entry.
REQ-015 Enqueued rdy SHALL be 1 if tag MSB is set (immediate), or IN_uopAvail, or tag equals any valid IN_wakeTag the same cycle; else 0.
REQ-016 Every valid entry with rdy=0 and tag equal to a valid IN_wakeTag SHALL set rdy=1 at the next edge; immediate tags never match wakeups.
REQ-017 The output register SHALL be free when !OUT_uop.valid || IN_issueReady; OUT_uop SHALL stay stable while valid && !IN_issueReady.
REQ-018 When the output register is free, the valid rdy entry with the oldest storeSqN (signed difference compare) SHALL be moved into OUT_uop and freed at the same edge; none ready -> OUT_uop.valid=0.
REQ-019 Entries woken in cycle N SHALL be issue-eligible in cycle N+1 at the earliest; minimum enqueue-to-OUT_uop latency is 2 cycles (enqueue edge, issue edge).
REQ-020 OUT_full SHALL be registered, 1 when occupancy after the edge equals DEPTH; an issue in the same cycle as full SHALL NOT permit enqueue that cycle.
REQ-021 When IN_branch.taken && (IN_branch.flush || $signed(storeSqN - IN_branch.storeSqN) > 0), matching entries, OUT_uop and IN_uop SHALL be invalidated at that edge; equal storeSqN survives.
REQ-022 A flush kill SHALL take priority over issue and enqueue of the same uop in the same cycle.
REQ-023 Occupancy counter SHALL be width $clog2(DEPTH)+1 and equal the number of valid entries at all times, including after partial kills.
REQ-024 No entry SHALL ever be issued twice; an entry killed while its selection is pending SHALL NOT appear on OUT_uop.

Reset
REQ-025 On rst: all entry valid=0, occupancy=0, OUT_full=0, OUT_uop.valid=0, other OUT_uop fields don't-care.
REQ-026 rst SHALL override simultaneous enqueue, wakeup, issue and branch inputs.

Configuration
REQ-027 Macro STDIQ_BYPASS_EN: when defined, an IN_uop with rdy=1 per REQ-015, no rdy entry in the queue, output register free and no kill SHALL be written directly into OUT_uop without occupying an entry (latency 1 cycle).
REQ-028 Without STDIQ_BYPASS_EN: every uop SHALL pass through an entry; latency per REQ-019.

Verification
REQ-029 Reset, then enqueue imm tag (MSB=1), storeSqN=5, IN_issueReady=1 -> OUT_uop.valid=1, storeSqN=5 two cycles after enqueue (one with STDIQ_BYPASS_EN).
REQ-030 Enqueue tags 0x12 (sqN 3) and 0x13 (sqN 2), IN_uopAvail=0; wake 0x12 then 0x13 next cycle -> sqN 3 issues first, then sqN 2; wake both same cycle -> sqN 2 first.
REQ-031 Fill DEPTH=8 with non-ready uops -> OUT_full=1; 9th IN_uop ignored; wake one tag -> one issue, OUT_full=0 next cycle, occupancy 7.
REQ-032 Entries sqN 4,6,8 ready, IN_issueReady=0; branch taken, storeSqN=5, flush=0 -> sqN 6,8 killed, OUT_uop holds/becomes sqN 4 only; occupancy consistent.
REQ-033 IN_branch.flush=1 concurrent with enqueue and a held OUT_uop -> queue empty, OUT_uop.valid=0, OUT_full=0 next cycle.
REQ-034 rst asserted while queue holds 5 entries and OUT_uop valid -> next cycle all empty, no later issue of old entries.
